// File: rtl/l2_bus_arbiter_2p.sv
// Purpose: round-robin arbiter sharing one L2 memory port between I-cache (p0) and D-cache (p1) miss paths.
// Latency: grant one cycle after request; L2 side and grants are combinational from registered state.
// Backpressure: owner held while l2_ack stalls (no timeout); forced release after BURST_LEN acks via one GAP cycle.
module l2_bus_arbiter_2p #(
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_mem_en,
   input  logic        p0_mem_wr_en,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wr_data,
   output logic        p0_rd_granted,
   output logic        p0_wr_granted,
   input  logic        p1_mem_en,
   input  logic        p1_mem_wr_en,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wr_data,
   output logic        p1_rd_granted,
   output logic        p1_wr_granted,
   output logic [31:0] p_rd_data,
   output logic        p0_ack,
   output logic        p1_ack,
   output logic        l2_en,
   output logic        l2_wr_en,
   output logic [31:0] l2_addr,
   output logic [31:0] l2_wr_data,
   input  logic [31:0] l2_rd_data,
   input  logic        l2_ack,
   output logic [1:0]  owner
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BURST_LEN);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             last;
   logic             last_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             arb_req;
   logic             arb_port;
   logic             own_port;
   logic             own_en;
   logic             burst_done;

   // Pick a winner for IDLE/GAP: lone requester wins, a tie goes to the port that did not own last.
   always_comb begin
      arb_req  = p0_mem_en | p1_mem_en;
      arb_port = p1_mem_en;
      if (p0_mem_en && p1_mem_en) begin
         arb_port = ~last;
      end
   end

   // Current owner's request and the burst-limit hit on this ack.
   always_comb begin
      own_port   = (state == OWN1);
      own_en     = own_port ? p1_mem_en : p0_mem_en;
      burst_done = ((cnt + CNT_ONE) == BEAT_MAX);
   end

   // Next-state, last-owner and beat-counter logic.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE, GAP: begin
            if (arb_req) begin
               state_nxt = arb_port ? OWN1 : OWN0;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         OWN0, OWN1: begin
            if (l2_ack) begin
               cnt_nxt = cnt + CNT_ONE;
            end
            // A dropped request releases immediately; otherwise the burst limit forces a GAP.
            if (!own_en) begin
               state_nxt = IDLE;
               last_nxt  = own_port;
            end else if (l2_ack && burst_done) begin
               state_nxt = GAP;
               last_nxt  = own_port;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State registers; reset drops ownership and lets port 0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Grant decode and L2 mux; grants follow the live wr_en so read/write turnaround is legal mid-grant.
   always_comb begin
      p0_rd_granted = 1'b0;
      p0_wr_granted = 1'b0;
      p1_rd_granted = 1'b0;
      p1_wr_granted = 1'b0;
      p0_ack        = 1'b0;
      p1_ack        = 1'b0;
      l2_en         = 1'b0;
      l2_wr_en      = 1'b0;
      l2_addr       = '0;
      l2_wr_data    = '0;
      owner         = 2'd0;
      if (!rst) begin
         case (state)
            OWN0: begin
               p0_rd_granted = ~p0_mem_wr_en;
               p0_wr_granted = p0_mem_wr_en;
               p0_ack        = l2_ack;
               l2_en         = p0_mem_en;
               l2_wr_en      = p0_mem_en & p0_mem_wr_en;
               l2_addr       = p0_addr;
               l2_wr_data    = p0_wr_data;
               owner         = 2'd1;
            end
            OWN1: begin
               p1_rd_granted = ~p1_mem_wr_en;
               p1_wr_granted = p1_mem_wr_en;
               p1_ack        = l2_ack;
               l2_en         = p1_mem_en;
               l2_wr_en      = p1_mem_en & p1_mem_wr_en;
               l2_addr       = p1_addr;
               l2_wr_data    = p1_wr_data;
               owner         = 2'd2;
            end
            default: begin
               owner = 2'd0;
            end
         endcase
      end
   end

   // Read data is broadcast; each consumer qualifies it with its own ack.
   assign p_rd_data = l2_rd_data;

endmodule

// File: tb/tb_l2_bus_arbiter_2p.sv
// Purpose: directed self-checking bench for l2_bus_arbiter_2p with an ack-routing scoreboard.
// Latency: inputs driven 1 time unit after posedge, checks 2 units after posedge and at negedge.
// Backpressure: l2_ack driven per beat by the bench; expected owner/data queued per driven beat.
module tb_l2_bus_arbiter_2p;

   logic        clk;
   logic        rst;
   logic        p0_mem_en, p0_mem_wr_en;
   logic [31:0] p0_addr, p0_wr_data;
   logic        p0_rd_granted, p0_wr_granted;
   logic        p1_mem_en, p1_mem_wr_en;
   logic [31:0] p1_addr, p1_wr_data;
   logic        p1_rd_granted, p1_wr_granted;
   logic [31:0] p_rd_data;
   logic        p0_ack, p1_ack;
   logic        l2_en, l2_wr_en;
   logic [31:0] l2_addr, l2_wr_data;
   logic [31:0] l2_rd_data;
   logic        l2_ack;
   logic [1:0]  owner;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   l2_bus_arbiter_2p #(.BURST_LEN(8), .CNT_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .p0_mem_en     (p0_mem_en),
      .p0_mem_wr_en  (p0_mem_wr_en),
      .p0_addr       (p0_addr),
      .p0_wr_data    (p0_wr_data),
      .p0_rd_granted (p0_rd_granted),
      .p0_wr_granted (p0_wr_granted),
      .p1_mem_en     (p1_mem_en),
      .p1_mem_wr_en  (p1_mem_wr_en),
      .p1_addr       (p1_addr),
      .p1_wr_data    (p1_wr_data),
      .p1_rd_granted (p1_rd_granted),
      .p1_wr_granted (p1_wr_granted),
      .p_rd_data     (p_rd_data),
      .p0_ack        (p0_ack),
      .p1_ack        (p1_ack),
      .l2_en         (l2_en),
      .l2_wr_en      (l2_wr_en),
      .l2_addr       (l2_addr),
      .l2_wr_data    (l2_wr_data),
      .l2_rd_data    (l2_rd_data),
      .l2_ack        (l2_ack),
      .owner         (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one L2 beat and record which port must see the ack.
   task automatic beat(input logic [31:0] d, input logic port);
      exp_t e;
      l2_ack     = 1'b1;
      l2_rd_data = d;
      e.port     = port;
      e.data     = d;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every queued beat must appear on exactly the expected port's ack.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("sb_p0_ack", 32'(p0_ack), 32'(e.port == 1'b0));
         chk("sb_p1_ack", 32'(p1_ack), 32'(e.port == 1'b1));
         chk("sb_rd_data", p_rd_data, e.data);
      end else if (p0_ack || p1_ack) begin
         chk("sb_spurious_ack", 32'({p1_ack, p0_ack}), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with both ports requesting and a stray ack.
      rst = 1'b1;
      p0_mem_en = 1'b1; p0_mem_wr_en = 1'b0; p0_addr = 32'h0; p0_wr_data = 32'h0;
      p1_mem_en = 1'b1; p1_mem_wr_en = 1'b0; p1_addr = 32'h0; p1_wr_data = 32'h0;
      l2_ack = 1'b1; l2_rd_data = 32'h1234_5678;
      #2;
      chk("rst_p0_rd", 32'(p0_rd_granted), 32'd0);
      chk("rst_p1_rd", 32'(p1_rd_granted), 32'd0);
      chk("rst_p0_ack", 32'(p0_ack), 32'd0);
      chk("rst_p1_ack", 32'(p1_ack), 32'd0);
      chk("rst_l2_en", 32'(l2_en), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      tick();
      tick();
      chk("rst_hold_owner", 32'(owner), 32'd0);
      rst = 1'b0;
      l2_ack = 1'b0;
      #1;
      chk("rel_owner_pre", 32'(owner), 32'd0);
      tick();
      chk("rel_owner", 32'(owner), 32'd1);
      chk("rel_p0_rd", 32'(p0_rd_granted), 32'd1);
      chk("rel_p1_rd", 32'(p1_rd_granted), 32'd0);
      p0_mem_en = 1'b0; p1_mem_en = 1'b0;
      #1;
      chk("drop_l2_en", 32'(l2_en), 32'd0);
      tick();
      chk("drop_idle", 32'(owner), 32'd0);

      // Contention with last=0: port 1 wins, then port 0 after port 1 releases.
      p0_mem_en = 1'b1; p1_mem_en = 1'b1;
      tick();
      chk("cont_owner1", 32'(owner), 32'd2);
      chk("cont_p0_rd", 32'(p0_rd_granted), 32'd0);
      chk("cont_p1_rd", 32'(p1_rd_granted), 32'd1);
      beat(32'hA5A5_0001, 1'b1);
      #1;
      chk("cont_p0_ack", 32'(p0_ack), 32'd0);
      chk("cont_p1_ack", 32'(p1_ack), 32'd1);
      tick();
      p1_mem_en = 1'b0; l2_ack = 1'b0;
      tick();
      chk("cont_idle", 32'(owner), 32'd0);
      tick();
      chk("cont_owner0", 32'(owner), 32'd1);
      beat(32'hA5A5_0002, 1'b0);
      tick();
      p0_mem_en = 1'b0; l2_ack = 1'b0;
      tick();

      // Single reader on port 1: 8 acks, one GAP cycle, then re-grant.
      p1_mem_en = 1'b1; p1_mem_wr_en = 1'b0; p1_addr = 32'h0000_4020;
      tick();
      chk("rd_p1_rd", 32'(p1_rd_granted), 32'd1);
      chk("rd_l2_addr", l2_addr, 32'h0000_4020);
      chk("rd_l2_en", 32'(l2_en), 32'd1);
      chk("rd_l2_wr_en", 32'(l2_wr_en), 32'd0);
      for (int i = 0; i < 8; i++) begin
         beat(32'h1000_0000 + 32'(i), 1'b1);
         #1;
         chk("rd_owner_beat", 32'(owner), 32'd2);
         tick();
      end
      chk("rd_gap_owner", 32'(owner), 32'd0);
      chk("rd_gap_l2_en", 32'(l2_en), 32'd0);
      chk("rd_gap_addr", l2_addr, 32'd0);
      chk("rd_gap_grant", 32'(p1_rd_granted), 32'd0);
      tick();
      chk("rd_regrant", 32'(owner), 32'd2);
      p1_mem_en = 1'b0; l2_ack = 1'b0;
      tick();

      // Forced fairness: both ports request continuously, ack every cycle.
      p0_mem_en = 1'b1; p1_mem_en = 1'b1;
      tick();
      for (int g = 0; g < 3; g++) begin
         for (int b = 0; b < 8; b++) begin
            beat(32'hF000_0000 + 32'(g * 16 + b), (g % 2) == 1);
            #1;
            chk("fair_owner", 32'(owner), 32'(g % 2 + 1));
            tick();
         end
         chk("fair_gap", 32'(owner), 32'd0);
         if (g == 2) begin
            p0_mem_en = 1'b0; p1_mem_en = 1'b0; l2_ack = 1'b0;
         end
         tick();
      end
      chk("fair_idle", 32'(owner), 32'd0);

      // Write path and mid-grant turnaround to read.
      p0_mem_en = 1'b1; p0_mem_wr_en = 1'b1; p0_addr = 32'h0000_0100; p0_wr_data = 32'hDEAD_BEEF;
      tick();
      chk("wr_p0_wr", 32'(p0_wr_granted), 32'd1);
      chk("wr_p0_rd", 32'(p0_rd_granted), 32'd0);
      chk("wr_l2_wr_en", 32'(l2_wr_en), 32'd1);
      chk("wr_l2_wr_data", l2_wr_data, 32'hDEAD_BEEF);
      beat(32'h0, 1'b0);
      tick();
      l2_ack = 1'b0; p0_mem_wr_en = 1'b0;
      #1;
      chk("turn_p0_rd", 32'(p0_rd_granted), 32'd1);
      chk("turn_p0_wr", 32'(p0_wr_granted), 32'd0);
      chk("turn_l2_wr_en", 32'(l2_wr_en), 32'd0);
      p0_mem_en = 1'b0;
      tick();

      // Async reset after the 3rd ack of an OWN1 burst.
      p1_mem_en = 1'b1; p1_addr = 32'h0000_4040;
      tick();
      for (int i = 0; i < 3; i++) begin
         beat(32'h2000_0000 + 32'(i), 1'b1);
         tick();
      end
      l2_ack = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_owner", 32'(owner), 32'd0);
      chk("arst_p1_rd", 32'(p1_rd_granted), 32'd0);
      chk("arst_l2_en", 32'(l2_en), 32'd0);
      chk("arst_l2_addr", l2_addr, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_regain", 32'(owner), 32'd2);
      for (int i = 0; i < 8; i++) begin
         beat(32'h3000_0000 + 32'(i), 1'b1);
         #1;
         chk("arst_burst_owner", 32'(owner), 32'd2);
         tick();
      end
      chk("arst_gap", 32'(owner), 32'd0);
      p1_mem_en = 1'b0; l2_ack = 1'b0;
      tick();
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
